magic_packet_checker: RTL and testbench

- Companion stage to the magic packet tracker in FIFO formal/simulation harnesses.
- Upstream role: selects and latches the magic packet on a nondeterministic capture request, then drives the tracker's captured input.
- Downstream role: consumes the tracker's cnt to detect when the magic packet leaves the FIFO, checks its data and order, and raises sticky error flags for assertions.

---
 rtl/magic_packet_checker.sv | 139 +++++++++++++
 tb/tb_magic_packet_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/magic_packet_checker.sv
// Magic packet checker for FIFO harnesses.
// Captures one "magic" packet from the write side when capture_en accompanies an accepted push.
// It then watches the companion tracker's cnt to see the packet leave the FIFO, and checks the
// popped data and the exit order. Problems are reported on sticky error flags.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push, pop     FIFO push/pop requests
//   full, empty   FIFO status flags
//   data_in       FIFO write data
//   data_out      FIFO head data, valid when ~empty
//   capture_en    free capture trigger, honoured only before capture
//   cnt           tracker count; reaches 1 when the magic packet is at the head
//   captured      magic packet latched; feeds the tracker
//   magic_data    latched magic packet value
//   exit_pulse    combinational pulse when the magic packet pops with matching data
//   done          magic packet has left the FIFO (sticky)
//   err_data      popped magic data differed from magic_data (sticky)
//   err_lost      cnt/empty inconsistent while tracking (sticky)
//   err_timeout   packet stayed in the FIFO for TIMEOUT cycles (sticky)
module magic_packet_checker #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNTWID  = $clog2(DEPTH) + 1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              full,
  input  logic              empty,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  data_out,
  input  logic              capture_en,
  input  logic [CNTWID-1:0] cnt,
  output logic              captured,
  output logic [WIDTH-1:0]  magic_data,
  output logic              exit_pulse,
  output logic              done,
  output logic              err_data,
  output logic              err_lost,
  output logic              err_timeout
);

  localparam int unsigned TimerW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);

  typedef enum logic [1:0] {
    StWait,
    StTrack,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   magic_q, magic_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               err_data_q, err_data_d;
  logic               err_lost_q, err_lost_d;
  logic               err_timeout_q, err_timeout_d;

  logic capture;
  logic exit_hit;

  assign capture  = push & ~full & capture_en;
  // A pop on an empty FIFO never counts as the exit.
  assign exit_hit = pop & ~empty & (cnt == CNTWID'(1));

  always_comb begin
    state_d       = state_q;
    magic_d       = magic_q;
    timer_d       = timer_q;
    err_data_d    = err_data_q;
    err_lost_d    = err_lost_q;
    err_timeout_d = err_timeout_q;
    exit_pulse    = 1'b0;

    unique case (state_q)
      StWait: begin
        if (capture) begin
          state_d = StTrack;
          magic_d = data_in;
          timer_d = '0;
        end
      end
      StTrack: begin
        // cnt includes the magic packet, so it can be neither 0 nor nonzero with an empty FIFO.
        if ((cnt == '0) || (empty && (cnt != '0))) begin
          err_lost_d = 1'b1;
        end
        if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end
        if (exit_hit) begin
          state_d = StDone;
          if (data_out == magic_q) begin
            exit_pulse = 1'b1;
          end else begin
            err_data_d = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (timer_d == TimerMax)) begin
          err_timeout_d = 1'b1;
        end
      end
      StDone: begin
        // Terminal until reset.
      end
      default: begin
        state_d = StWait;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StWait;
      magic_q       <= '0;
      timer_q       <= '0;
      err_data_q    <= 1'b0;
      err_lost_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      magic_q       <= magic_d;
      timer_q       <= timer_d;
      err_data_q    <= err_data_d;
      err_lost_q    <= err_lost_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign captured    = (state_q != StWait);
  assign done        = (state_q == StDone);
  assign magic_data  = magic_q;
  assign err_data    = err_data_q;
  assign err_lost    = err_lost_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_magic_packet_checker.sv
// Bench for magic_packet_checker: two instances (TIMEOUT=64 and TIMEOUT=4) share the stimulus.
// A behavioural model tracks the packet's life for each timeout; a vector table and a few
// hand-written sequences cover the directed scenarios, then random stimulus follows.
module tb_magic_packet_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0, pop = 1'b0, full = 1'b0, empty = 1'b1, capture_en = 1'b0;
  logic [7:0] data_in = '0, data_out = '0;
  logic [3:0] cnt = '0;

  logic       cap0, exit0, done0, ed0, el0, et0;
  logic       cap1, exit1, done1, ed1, el1, et1;
  logic [7:0] mag0, mag1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  magic_packet_checker #(.DEPTH(8), .WIDTH(8), .TIMEOUT(64)) dut64 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .full(full), .empty(empty),
    .data_in(data_in), .data_out(data_out), .capture_en(capture_en), .cnt(cnt),
    .captured(cap0), .magic_data(mag0), .exit_pulse(exit0), .done(done0),
    .err_data(ed0), .err_lost(el0), .err_timeout(et0)
  );

  magic_packet_checker #(.DEPTH(8), .WIDTH(8), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .full(full), .empty(empty),
    .data_in(data_in), .data_out(data_out), .capture_en(capture_en), .cnt(cnt),
    .captured(cap1), .magic_data(mag1), .exit_pulse(exit1), .done(done1),
    .err_data(ed1), .err_lost(el1), .err_timeout(et1)
  );

  // ---------------- reference model ----------------
  // phase: 0 = waiting for capture, 1 = packet inside FIFO, 2 = packet gone
  int         m_ph[2];
  logic [7:0] m_magic[2];
  int         m_res[2];
  bit         m_ed[2], m_el[2], m_et[2];
  int         tmo[2] = '{64, 4};

  function automatic logic [15:0] model_out(int k);
    logic ex;
    ex = (m_ph[k] == 1) && pop && !empty && (cnt == 4'd1) && (data_out == m_magic[k]);
    return {2'b00, m_ph[k] != 0, ex, m_ph[k] == 2, m_ed[k], m_el[k], m_et[k], m_magic[k]};
  endfunction

  function automatic logic [15:0] dut_out(int k);
    if (k == 0) return {2'b00, cap0, exit0, done0, ed0, el0, et0, mag0};
    return {2'b00, cap1, exit1, done1, ed1, el1, et1, mag1};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_magic[k] = '0; m_res[k] = 0;
      m_ed[k] = 0; m_el[k] = 0; m_et[k] = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (m_ph[k] == 0) begin
        if (push && !full && capture_en) begin
          m_ph[k] = 1; m_magic[k] = data_in; m_res[k] = 0;
        end
      end else if (m_ph[k] == 1) begin
        if (cnt == 0 || (empty && cnt != 0)) m_el[k] = 1;
        if (pop && !empty && cnt == 1) begin
          if (data_out != m_magic[k]) m_ed[k] = 1;
          m_ph[k] = 2;
        end else begin
          m_res[k]++;
          if (tmo[k] > 0 && m_res[k] >= tmo[k]) m_et[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_t64", dut_out(0), model_out(0));
    chk("model_t4", dut_out(1), model_out(1));
  endtask

  task automatic idle();
    push = 0; pop = 0; full = 0; empty = 0; capture_en = 0;
    data_in = '0; data_out = '0; cnt = 4'd1;
  endtask

  // Inputs are set just after a falling edge; check, clock, advance to the next falling edge.
  task automatic step();
    #1 check_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    #2 check_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst_first;
    bit         push, pop, full, empty, cap;
    logic [7:0] din, dout;
    logic [3:0] cnt;
    logic [4:0] exp_flags;  // {captured, exit_pulse, done, err_data, err_lost}
    logic [7:0] exp_magic;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit pu, bit po, bit fu, bit em, bit ca, logic [7:0] di,
                              logic [7:0] dq, logic [3:0] c, logic [4:0] f, logic [7:0] m);
    vec_t v;
    v.rst_first = r; v.push = pu; v.pop = po; v.full = fu; v.empty = em; v.cap = ca;
    v.din = di; v.dout = dq; v.cnt = c; v.exp_flags = f; v.exp_magic = m;
    return v;
  endfunction

  initial begin
    // In-order: 0x11, 0x22, then 0x33 captured; exits on the third pop.
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 8'h11, 8'h00, 4'd0, 5'b00000, 8'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h22, 8'h00, 4'd0, 5'b00000, 8'h00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h33, 8'h00, 4'd0, 5'b00000, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h11, 4'd3, 5'b10000, 8'h33));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h11, 4'd3, 5'b10000, 8'h33));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h22, 4'd2, 5'b10000, 8'h33));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h33, 4'd1, 5'b11000, 8'h33));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'd0, 5'b10100, 8'h33));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h77, 8'h33, 4'd1, 5'b10100, 8'h33));
    // Push while full never captures; later 0x44 does.
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 8'h99, 8'h00, 4'd0, 5'b00000, 8'h00));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 4'd0, 5'b00000, 8'h00));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 8'h44, 8'h00, 4'd0, 5'b00000, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 4'd1, 5'b10000, 8'h44));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 8'h44, 4'd1, 5'b11000, 8'h44));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 4'd0, 5'b10100, 8'h44));
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    idle();
    #1;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst_first) do_reset();
      push = tbl[i].push; pop = tbl[i].pop; full = tbl[i].full; empty = tbl[i].empty;
      capture_en = tbl[i].cap; data_in = tbl[i].din; data_out = tbl[i].dout; cnt = tbl[i].cnt;
      #1 chk($sformatf("vec%0d", i), {3'b000, cap0, exit0, done0, ed0, el0, mag0},
             {3'b000, tbl[i].exp_flags, tbl[i].exp_magic});
      step();
    end

    // Mismatching data at exit: err_data, no pulse, flags held while idle.
    do_reset();
    push = 1; capture_en = 1; data_in = 8'hA5; empty = 1; cnt = 4'd0;
    step();
    idle();
    pop = 1; data_out = 8'h5A; cnt = 4'd1;
    #1 chk("bad_data_no_pulse", {15'd0, exit0}, 16'd0);
    step();
    idle();
    empty = 1; cnt = 4'd0;
    repeat (10) step();
    chk("bad_data_held", {12'd0, ed0, el0, et0, done0}, 16'b1001);

    // cnt drops to 0 while tracking: err_lost next cycle, still tracking.
    do_reset();
    push = 1; capture_en = 1; data_in = 8'h3C; empty = 1; cnt = 4'd0;
    step();
    idle();
    cnt = 4'd0;
    #1 chk("lost_before", {15'd0, el0}, 16'd0);
    step();
    chk("lost_after", {13'd0, el0, cap0, done0}, 16'b110);

    // Residency timeout on the TIMEOUT=4 instance, then asynchronous reset mid-track.
    do_reset();
    push = 1; capture_en = 1; data_in = 8'h5E;
    step();
    idle();
    repeat (3) step();
    chk("timeout_3cyc", {15'd0, et1}, 16'd0);
    step();
    chk("timeout_4cyc", {14'd0, et1, et0}, 16'b10);
    step();
    #2 rst = 1'b1;
    #1 chk("async_rst_t4", dut_out(1), 16'd0);
    chk("async_rst_t64", dut_out(0), 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random stimulus against the model.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin
        push       = ($urandom_range(0, 1) == 1);
        pop        = ($urandom_range(0, 1) == 1);
        full       = ($urandom_range(0, 3) == 0);
        empty      = ($urandom_range(0, 3) == 0);
        capture_en = ($urandom_range(0, 3) == 0);
        data_in    = 8'($urandom);
        data_out   = ($urandom_range(0, 1) == 1) ? m_magic[0] : 8'($urandom);
        cnt        = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 8)) : 4'd1;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
